// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: computes mult/multu/div/divu into private HI/LO,
// holds E_Busy for a fixed latency, and serves mthi/mtlo writes and mfhi/mflo reads.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_Start,
  input  logic [2:0]  E_MDOp,
  input  logic        E_RdHi,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  output logic        E_Busy,
  output logic [31:0] E_MDOut,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_MFHL  = 3'd7
  } md_op_e;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     tmp_hi_q, tmp_hi_d, tmp_lo_q, tmp_lo_d;
  logic            pend_q, pend_d;

  md_op_e          op;
  logic            is_mul, is_div, is_sdiv, start;
  logic [63:0]     prod_s, prod_u;
  logic [31:0]     abs_a, abs_b, div_den, uq, ur, quo, rem;
  logic [63:0]     result;

  assign op      = md_op_e'(E_MDOp);
  assign is_mul  = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div  = (op == OP_DIV)  || (op == OP_DIVU);
  assign is_sdiv = (op == OP_DIV);
  assign start   = E_Start && (is_mul || is_div);

  assign prod_s = $signed({{32{E_A[31]}}, E_A}) * $signed({{32{E_B[31]}}, E_B});
  assign prod_u = {32'd0, E_A} * {32'd0, E_B};

  // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing.
  assign abs_a   = (is_sdiv && E_A[31]) ? -E_A : E_A;
  assign abs_b   = (is_sdiv && E_B[31]) ? -E_B : E_B;
  assign div_den = (abs_b == 32'd0) ? 32'd1 : abs_b;
  assign uq      = abs_a / div_den;
  assign ur      = abs_a % div_den;
  assign quo     = (is_sdiv && (E_A[31] ^ E_B[31])) ? -uq : uq;
  assign rem     = (is_sdiv && E_A[31]) ? -ur : ur;

  always_comb begin
    unique case (op)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      default:  result = {rem, quo};
    endcase
  end

  // NOTE: every next-state signal gets its hold value first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    tmp_hi_d = tmp_hi_q;
    tmp_lo_d = tmp_lo_q;
    pend_d   = pend_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          tmp_hi_d = result[63:32];
          tmp_lo_d = result[31:0];
          pend_d   = !(is_div && (E_B == 32'd0));
          cnt_d    = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          state_d  = S_RUN;
        end else if (!E_Start && op == OP_MTHI) begin
          hi_d = E_A;
        end else if (!E_Start && op == OP_MTLO) begin
          lo_d = E_A;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          pend_d  = 1'b0;
          if (pend_q) begin
            hi_d = tmp_hi_q;
            lo_d = tmp_lo_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      tmp_hi_q <= '0;
      tmp_lo_q <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      tmp_hi_q <= tmp_hi_d;
      tmp_lo_q <= tmp_lo_d;
      pend_q   <= pend_d;
    end
  end

  assign E_Busy  = (state_q == S_RUN);
  assign E_MDOut = E_RdHi ? hi_q : lo_q;
  assign HI      = hi_q;
  assign LO      = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: vector table through a scoreboard plus hand-written
// sequences for in-flight interference and mid-operation reset.
module tb_e_mdu;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_MFHL  = 3'd7;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [31:0] pre_hi, pre_lo;
    logic [31:0] exp_hi, exp_lo;
    int          cycles;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        E_Start;
  logic [2:0]  E_MDOp;
  logic        E_RdHi;
  logic [31:0] E_A, E_B;
  logic        E_Busy;
  logic [31:0] E_MDOut, HI, LO;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  vec_t vecs[10];

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .E_Start (E_Start),
    .E_MDOp  (E_MDOp),
    .E_RdHi  (E_RdHi),
    .E_A     (E_A),
    .E_B     (E_B),
    .E_Busy  (E_Busy),
    .E_MDOut (E_MDOut),
    .HI      (HI),
    .LO      (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic write_reg(input logic [2:0] op, input logic [31:0] d);
    @(negedge clk);
    E_MDOp = op;
    E_A    = d;
    @(negedge clk);
    E_MDOp = OP_NONE;
  endtask

  // Called at a negedge after the start edge; counts negedges that see E_Busy high.
  task automatic wait_idle(input int n0, output int n);
    n = n0;
    while (E_Busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic pop_and_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_scoreboard: got empty queue, expected one entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_hi"}, HI, e.hi);
      check({tag, "_lo"}, LO, e.lo);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    write_reg(OP_MTHI, v.pre_hi);
    write_reg(OP_MTLO, v.pre_lo);
    @(negedge clk);
    E_Start = 1'b1;
    E_MDOp  = v.op;
    E_A     = v.a;
    E_B     = v.b;
    sb.push_back('{hi: v.exp_hi, lo: v.exp_lo});
    @(negedge clk);
    E_Start = 1'b0;
    E_MDOp  = OP_NONE;
    E_A     = $urandom;
    E_B     = $urandom;
    wait_idle(0, n);
    check({tag, "_busy_cycles"}, 32'(n), 32'(v.cycles));
    pop_and_check(tag);
    E_MDOp = OP_MFHL;
    E_RdHi = 1'b1;
    #1 check({tag, "_mfhi"}, E_MDOut, v.exp_hi);
    E_RdHi = 1'b0;
    #1 check({tag, "_mflo"}, E_MDOut, v.exp_lo);
    E_MDOp = OP_NONE;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected bench to end");
    $fatal(1);
  end

  initial begin
    int n;
    //        op        a             b             pre_hi        pre_lo        exp_hi        exp_lo        cyc
    vecs[0] = '{OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 32'h80000000, 10};
    vecs[4] = '{OP_DIVU,  32'd100,      32'h00000000, 32'h00000011, 32'h00000022, 32'h00000011, 32'h00000022, 10};
    vecs[5] = '{OP_DIVU,  32'd100,      32'd7,        32'h00000000, 32'h00000000, 32'h00000002, 32'h0000000E, 10};
    vecs[6] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000000, 32'h00000000, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[7] = '{OP_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000000, 32'h00000000, 32'h3FFFFFFF, 32'h00000001, 5};
    vecs[8] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'h000000AA, 32'h000000BB, 32'h000000AA, 32'h000000BB, 10};
    vecs[9] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h00000000, 32'h00000000, 32'h40000000, 32'h00000000, 5};

    reset   = 1'b0;
    E_Start = 1'b0;
    E_MDOp  = OP_NONE;
    E_RdHi  = 1'b0;
    E_A     = '0;
    E_B     = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_busy", {31'd0, E_Busy}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    check("reset_mdout", E_MDOut, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // In-flight mtlo and a second start must both be ignored; mflo reads the old LO.
    write_reg(OP_MTHI, 32'h66);
    write_reg(OP_MTLO, 32'h77);
    @(negedge clk);
    E_Start = 1'b1;
    E_MDOp  = OP_MULT;
    E_A     = 32'd6;
    E_B     = 32'd7;
    sb.push_back('{hi: 32'd0, lo: 32'd42});
    @(negedge clk);
    check("seqA_busy1", {31'd0, E_Busy}, 32'd1);
    E_Start = 1'b0;
    E_MDOp  = OP_MTLO;
    E_A     = 32'h5;
    @(negedge clk);
    check("seqA_busy2", {31'd0, E_Busy}, 32'd1);
    E_Start = 1'b1;
    E_MDOp  = OP_MULT;
    E_A     = 32'd2;
    E_B     = 32'd2;
    @(negedge clk);
    E_Start = 1'b0;
    E_MDOp  = OP_MFHL;
    E_RdHi  = 1'b0;
    #1 check("seqA_mflo_old", E_MDOut, 32'h77);
    @(negedge clk);
    E_MDOp = OP_NONE;
    wait_idle(3, n);
    check("seqA_busy_cycles", 32'(n), 32'd5);
    pop_and_check("seqA");
    @(negedge clk);
    @(negedge clk);
    check("seqA_no_second_busy", {31'd0, E_Busy}, 32'd0);
    check("seqA_lo_stable", LO, 32'd42);

    // Reset during a div aborts it; no late commit, then a fresh mult works.
    write_reg(OP_MTHI, 32'h12);
    @(negedge clk);
    E_Start = 1'b1;
    E_MDOp  = OP_DIV;
    E_A     = 32'd100;
    E_B     = 32'd3;
    sb.push_back('{hi: 32'd1, lo: 32'd33});
    @(negedge clk);
    E_Start = 1'b0;
    E_MDOp  = OP_NONE;
    @(negedge clk);
    @(negedge clk);
    check("seqB_busy_before_reset", {31'd0, E_Busy}, 32'd1);
    reset = 1'b0;
    sb.delete();
    #1;
    check("seqB_busy_after_reset", {31'd0, E_Busy}, 32'd0);
    check("seqB_hi_after_reset", HI, 32'd0);
    check("seqB_lo_after_reset", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check("seqB_no_late_busy", {31'd0, E_Busy}, 32'd0);
    check("seqB_no_late_hi", HI, 32'd0);
    check("seqB_no_late_lo", LO, 32'd0);
    run_vec('{OP_MULT, 32'hFFFFFFFD, 32'h00000004, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF4, 5}, "seqB_mult");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
